amo_master: RTL and testbench
=============================

# amo_master

Wishbone initiator that runs RV32A atomic instructions (lr.w, sc.w, amo*.w) on the tagged RAM bus. It sits between the processor's memory stage and the RAM bus port. It produces the tagged read and write transactions that the RAM bus responder uses for its reservation and lock logic. It returns the rd value and a completion pulse to the pipeline.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  reset; **one clock; reset is asynchronous and active-low**
- req_i  in  1  start request; sampled only in IDLE
- op_i  in  4  atomic op code (see Structure)
- req_addr_i  in  32  word address (rs1)
- req_data_i  in  32  operand (rs2)
- busy_o  out  1  high from the cycle after acceptance until done_o
- done_o  out  1  one-cycle completion pulse
- result_o  out  32  rd value; held until the next done_o
- err_o  out  1  valid with done_o: misaligned address or illegal op
- cyc_o, stb_o  out  1  Wishbone cycle and strobe
- we_o  out  1  write enable
- sel_o  out  4  always 4'b1111
- addr_o  out  32  bus address
- addr_tag_o  out  3  bits [2:1] = mode, bit [0] = LOCK/UNLOCK
- data_o  out  32  write data
- ack_i  in  1  responder acknowledge
- data_i  in  32  read data
- data_tag_i  in  1  sc.w failure flag from the responder

## Operation
FSM states: IDLE, RD, CALC, WR, DONE.

- **IDLE**
  - On req_i, latch op_i, req_addr_i and req_data_i.
  - If req_addr_i[1:0] != 0 or op_i is illegal, go to DONE with err_o=1 and result_o=0. No bus cycle is issued.
  - Otherwise, LR and AMO ops go to RD; SC goes to WR.
- **RD**
  - Drive cyc_o=stb_o=1, we_o=0.
  - LR uses tag {MODE_LRSC, LOCK}; AMO uses tag {MODE_AMO, LOCK}.
  - On ack_i, capture data_i as the old value.
  - LR then goes to DONE with result_o=old.
  - AMO then goes to CALC.
- **CALC**
  - cyc_o=stb_o=0 for exactly one cycle.
  - The registered new value is amo_alu(op, old, operand).
  - Go to WR.
- **WR**
  - Drive cyc_o=stb_o=1, we_o=1, data_o = new value (AMO) or operand (SC).
  - SC uses tag {MODE_LRSC, UNLOCK}; AMO uses tag {MODE_AMO, UNLOCK}.
  - On ack_i, go to DONE.
  - SC result_o = {31'b0, data_tag_i}: 0 means success, 1 means failure.
  - AMO result_o = old value.
- **DONE**
  - done_o=1 for one cycle, bus idle, then IDLE.

Behaviour rules:
- addr_o = latched req_addr_i for both phases of an AMO.
- ALU rules:
  - ADD wraps mod 2^32.
  - MIN/MAX use a signed 32-bit compare; MINU/MAXU use an unsigned compare.
  - SWAP stores the operand.
- If the responder stalls an AMO LOCK read (address already reserved), stay in RD with the strobe held. There is no timeout.
- req_i outside IDLE is ignored and not queued.
- Reset asserted mid-transaction: all outputs go to 0 immediately and the FSM goes to IDLE. The responder's reservation is cleared by the shared system reset.

## Timing
- Reset values:
  - cyc_o, stb_o, we_o, done_o, err_o, busy_o = 0
  - addr_o, data_o, result_o = 0
  - addr_tag_o = {MODE_NONE, UNLOCK}
  - sel_o = 4'b1111
- All outputs are registered.
- Request and strobe: req_i sampled in cycle 0 gives stb_o=1 and busy_o=1 in cycle 1.
- Strobe release: ack_i sampled high in cycle k gives stb_o=0 in cycle k+1. The next phase never starts in the same cycle as an ack.
- Latency, with ack 1 cycle after strobe: LR/SC done_o at cycle 3; AMO done_o at cycle 6.
- Error path: done_o in cycle 1 with no bus activity.
- The bus signals (cyc, stb, we, addr, tag, data) are stable while stb_o=1.

## Structure
- Tag macros (MODE_NONE, MODE_LRSC, MODE_AMO, LOCK, UNLOCK) come from tags.svh.
- New amo_ops.svh holds the op codes:
  - LR=0, SC=1, SWAP=2, ADD=3, XOR=4, AND=5, OR=6
  - MIN=7, MAX=8, MINU=9, MAXU=10
  - 11–15 are illegal.
- Sub-module amo_alu: combinational; inputs op, old and operand; output new.

## Test plan
- LR at 0x100 with memory holding 0x1234_5678 → one read with tag {LRSC,LOCK}; result_o=0x1234_5678; done_o at cycle 3.
- LR then SC at 0x100 with operand 0xAA → write with tag {LRSC,UNLOCK}, data_tag_i=0; result_o=0. A repeated SC gets data_tag_i=1, so result_o=1.
- AMOADD at 0x200 with old=0xFFFF_FFFF, operand=2 → read {AMO,LOCK}, one idle cycle, write 0x0000_0001 with {AMO,UNLOCK}; result_o=0xFFFF_FFFF.
- AMOMIN with old=0x8000_0000, operand=1 writes 0x8000_0000. AMOMINU with the same operands writes 0x0000_0001.
- Address 0x202, or op=12 → err_o=1 and done_o in cycle 1; cyc_o never asserted.
- rst_n_i low during the AMO WR phase → stb_o and cyc_o drop immediately; after release, a new LR completes normally.

Source files
------------

// File: rtl/amo_master_pkg.sv
// amo_master_pkg: bus tag encodings, RV32A op codes and FSM states for the atomic initiator
package amo_master_pkg;
  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_LRSC = 2'd1;
  localparam logic [1:0] MODE_AMO  = 2'd2;
  localparam logic LOCK   = 1'b1;
  localparam logic UNLOCK = 1'b0;
  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_e;
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MAXU;
  endfunction
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write value for amo*.w (SWAP and non-AMO ops store operand)
module amo_alu
  import amo_master_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  output logic [31:0] new_val
);
  logic lt_s, lt_u;
  assign lt_s = $signed(old) < $signed(operand);
  assign lt_u = old < operand;
  always_comb
    new_val = op == OP_ADD  ? old + operand :
              op == OP_XOR  ? old ^ operand :
              op == OP_AND  ? old & operand :
              op == OP_OR   ? old | operand :
              op == OP_MIN  ? (lt_s ? old : operand) :
              op == OP_MAX  ? (lt_s ? operand : old) :
              op == OP_MINU ? (lt_u ? old : operand) :
              op == OP_MAXU ? (lt_u ? operand : old) :
              operand;
endmodule

// File: rtl/amo_master.sv
// amo_master: Wishbone initiator running lr.w / sc.w / amo*.w as tagged read and write phases
module amo_master
  import amo_master_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] addr_o,
  output logic [2:0]  addr_tag_o,
  output logic [31:0] data_o,
  input  logic        ack_i,
  input  logic [31:0] data_i,
  input  logic        data_tag_i
);
  state_e      state;
  logic [3:0]  op_q;
  logic [31:0] operand_q, old_q, new_val;
  amo_alu u_alu (.op(op_q), .old(old_q), .operand(operand_q), .new_val(new_val));
  assign sel_o = 4'b1111;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state      <= S_IDLE;
      op_q       <= '0;
      operand_q  <= '0;
      old_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      result_o   <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      addr_tag_o <= {MODE_NONE, UNLOCK};
    end else begin
      case (state)
        S_IDLE:
          if (req_i) begin
            op_q      <= op_i;
            operand_q <= req_data_i;
            addr_o    <= req_addr_i;
            if (req_addr_i[1:0] != 2'b00 || !op_legal(op_i)) begin
              state    <= S_DONE;
              done_o   <= 1'b1;
              err_o    <= 1'b1;
              result_o <= '0;
            end else if (op_i == OP_SC) begin
              state      <= S_WR;
              busy_o     <= 1'b1;
              cyc_o      <= 1'b1;
              stb_o      <= 1'b1;
              we_o       <= 1'b1;
              data_o     <= req_data_i;
              addr_tag_o <= {MODE_LRSC, UNLOCK};
            end else begin
              state      <= S_RD;
              busy_o     <= 1'b1;
              cyc_o      <= 1'b1;
              stb_o      <= 1'b1;
              we_o       <= 1'b0;
              addr_tag_o <= {(op_i == OP_LR) ? MODE_LRSC : MODE_AMO, LOCK};
            end
          end
        // a stalled LOCK read simply holds the strobe here until acked
        S_RD:
          if (ack_i) begin
            old_q      <= data_i;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            addr_tag_o <= {MODE_NONE, UNLOCK};
            if (op_q == OP_LR) begin
              state    <= S_DONE;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              err_o    <= 1'b0;
              result_o <= data_i;
            end else
              state <= S_CALC;
          end
        S_CALC: begin
          state      <= S_WR;
          cyc_o      <= 1'b1;
          stb_o      <= 1'b1;
          we_o       <= 1'b1;
          data_o     <= new_val;
          addr_tag_o <= {MODE_AMO, UNLOCK};
        end
        S_WR:
          if (ack_i) begin
            state      <= S_DONE;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            addr_tag_o <= {MODE_NONE, UNLOCK};
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= 1'b0;
            result_o   <= (op_q == OP_SC) ? {31'b0, data_tag_i} : old_q;
          end
        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          err_o  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_amo_master.sv
// tb_amo_master: directed table, reset corner case and randomized ops against a memory/reservation model
module tb_amo_master;
  import amo_master_pkg::*;
  logic        clk_i = 1'b0, rst_n_i = 1'b0, req_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] req_addr_i = '0, req_data_i = '0;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [31:0] result_o, addr_o, data_o;
  logic [3:0]  sel_o;
  logic [2:0]  addr_tag_o;
  logic        ack_i = 1'b0, data_tag_i = 1'b0;
  logic [31:0] data_i = '0;

  amo_master dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .op_i(op_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .err_o(err_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .addr_o(addr_o),
    .addr_tag_o(addr_tag_o), .data_o(data_o), .ack_i(ack_i),
    .data_i(data_i), .data_tag_i(data_tag_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // responder: memory, LR/SC reservation, programmable wait states
  logic [31:0] bus_mem [logic [31:0]];
  int          lat = 1, wcnt = 0;
  logic        resv_v = 1'b0, bus_seen = 1'b0, in_stb = 1'b0;
  logic [31:0] resv_a = '0, wr_data = '0, s_addr = '0, s_data = '0;
  logic [2:0]  rd_tag = '0, wr_tag = '0, s_tag = '0;
  logic        s_we = 1'b0;

  initial forever begin
    @(posedge clk_i);
    #1;
    if (cyc_o) bus_seen = 1'b1;
    if (!rst_n_i) begin
      ack_i = 1'b0; wcnt = 0; in_stb = 1'b0;
    end else if (stb_o && !ack_i) begin
      if (!in_stb) begin
        in_stb = 1'b1;
        s_addr = addr_o; s_data = data_o; s_tag = addr_tag_o; s_we = we_o;
        chk("sel", 32'(sel_o), 32'hF);
      end else begin
        chk("stable_addr", addr_o, s_addr);
        chk("stable_data", data_o, s_data);
        chk("stable_tag_we", 32'({addr_tag_o, we_o}), 32'({s_tag, s_we}));
      end
      if (wcnt >= lat) begin
        ack_i = 1'b1; wcnt = 0; in_stb = 1'b0;
        if (!we_o) begin
          data_i = bus_mem.exists(addr_o) ? bus_mem[addr_o] : 32'h0;
          rd_tag = addr_tag_o;
          if (addr_tag_o == {MODE_LRSC, LOCK}) begin resv_v = 1'b1; resv_a = addr_o; end
        end else begin
          wr_tag = addr_tag_o; wr_data = data_o; data_tag_i = 1'b0;
          if (addr_tag_o[2:1] == MODE_LRSC) begin
            data_tag_i = !(resv_v && resv_a == addr_o);
            resv_v = 1'b0;
          end
          if (!data_tag_i) bus_mem[addr_o] = data_o;
        end
      end else begin
        ack_i = 1'b0; wcnt++;
      end
    end else begin
      ack_i = 1'b0; wcnt = 0;
    end
  end

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] res, output logic e, output int n);
    bus_seen = 1'b0; rd_tag = 3'b111; wr_tag = 3'b111; wr_data = 32'hBAD0BAD0;
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = op; req_addr_i = a; req_data_i = d;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n = 1;
    if (op_legal(op) && a[1:0] == 2'b00) chk("busy_c1", 32'(busy_o), 32'h1);
    while (!done_o && n < 300) begin @(posedge clk_i); #1; n++; end
    if (!done_o) chk("done_timeout", 32'(n), 32'hFFFF_FFFF);
    res = result_o; e = err_o;
  endtask

  // reference model from the architectural rules
  logic [31:0] ref_mem [logic [31:0]];
  logic        ref_rv = 1'b0;
  logic [31:0] ref_ra = '0;
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] o, input logic [31:0] v);
    int so = o, sv = v;
    case (op)
      3: return o + v;
      4: return o ^ v;
      5: return o & v;
      6: return o | v;
      7: return (so <= sv) ? o : v;
      8: return (so >= sv) ? o : v;
      9: return (o <= v) ? o : v;
      10: return (o >= v) ? o : v;
      default: return v;
    endcase
  endfunction
  task automatic ref_txn(input int op, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] res, output logic e, output int n, input int l);
    logic [31:0] old;
    e = 1'b0;
    if (a % 4 != 0 || op > 10) begin res = 0; e = 1'b1; n = 1; end
    else if (op == 0) begin res = ref_mem[a]; ref_rv = 1'b1; ref_ra = a; n = 2 + l; end
    else if (op == 1) begin
      res = (ref_rv && ref_ra == a) ? 0 : 1;
      if (res == 0) ref_mem[a] = d;
      ref_rv = 1'b0; n = 2 + l;
    end else begin
      old = ref_mem[a]; ref_mem[a] = ref_alu(op, old, d); res = old; n = 4 + 2 * l;
    end
  endtask

  typedef struct {
    logic [3:0] op; logic [31:0] addr, data; logic pre; logic [31:0] pre_val;
    logic [31:0] res; logic err; int cyc;
    logic rd; logic [2:0] rtag; logic wr; logic [2:0] wtag; logic [31:0] wdata;
  } vec_t;
  vec_t v [14];

  logic [31:0] res, eres, ra;
  logic        e, ee;
  int          n, en, op;

  initial begin
    v[0]  = '{OP_LR,   32'h100, 32'h0,    1, 32'h1234_5678, 32'h1234_5678, 0, 3, 1, 3'b011, 0, 3'b000, 32'h0};
    v[1]  = '{OP_SC,   32'h100, 32'hAA,   0, 32'h0,         32'h0,         0, 3, 0, 3'b000, 1, 3'b010, 32'hAA};
    v[2]  = '{OP_SC,   32'h100, 32'hAA,   0, 32'h0,         32'h1,         0, 3, 0, 3'b000, 1, 3'b010, 32'hAA};
    v[3]  = '{OP_ADD,  32'h200, 32'h2,    1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6, 1, 3'b101, 1, 3'b100, 32'h1};
    v[4]  = '{OP_MIN,  32'h204, 32'h1,    1, 32'h8000_0000, 32'h8000_0000, 0, 6, 1, 3'b101, 1, 3'b100, 32'h8000_0000};
    v[5]  = '{OP_MINU, 32'h208, 32'h1,    1, 32'h8000_0000, 32'h8000_0000, 0, 6, 1, 3'b101, 1, 3'b100, 32'h1};
    v[6]  = '{OP_MAX,  32'h20C, 32'h1,    1, 32'h8000_0000, 32'h8000_0000, 0, 6, 1, 3'b101, 1, 3'b100, 32'h1};
    v[7]  = '{OP_MAXU, 32'h210, 32'h1,    1, 32'h8000_0000, 32'h8000_0000, 0, 6, 1, 3'b101, 1, 3'b100, 32'h8000_0000};
    v[8]  = '{OP_SWAP, 32'h214, 32'hDEAD, 1, 32'h5,         32'h5,         0, 6, 1, 3'b101, 1, 3'b100, 32'hDEAD};
    v[9]  = '{OP_XOR,  32'h218, 32'h0F0F, 1, 32'hFF00,      32'hFF00,      0, 6, 1, 3'b101, 1, 3'b100, 32'hF00F};
    v[10] = '{OP_AND,  32'h21C, 32'hF0F0, 1, 32'h0FF0,      32'h0FF0,      0, 6, 1, 3'b101, 1, 3'b100, 32'h00F0};
    v[11] = '{OP_OR,   32'h220, 32'hF000, 1, 32'h000F,      32'h000F,      0, 6, 1, 3'b101, 1, 3'b100, 32'hF00F};
    v[12] = '{OP_ADD,  32'h202, 32'h1,    0, 32'h0,         32'h0,         1, 1, 0, 3'b000, 0, 3'b000, 32'h0};
    v[13] = '{4'd12,   32'h100, 32'h1,    0, 32'h0,         32'h0,         1, 1, 0, 3'b000, 0, 3'b000, 32'h0};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ctl", 32'({cyc_o, stb_o, we_o, done_o, err_o, busy_o}), 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_tag", 32'(addr_tag_o), 32'({MODE_NONE, UNLOCK}));
    chk("rst_sel", 32'(sel_o), 32'hF);
    rst_n_i = 1'b1;

    foreach (v[i]) begin
      if (v[i].pre) bus_mem[v[i].addr] = v[i].pre_val;
      run(v[i].op, v[i].addr, v[i].data, res, e, n);
      chk($sformatf("v%0d_result", i), res, v[i].res);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(v[i].err));
      chk($sformatf("v%0d_cycles", i), n, v[i].cyc);
      if (v[i].rd) chk($sformatf("v%0d_rd_tag", i), 32'(rd_tag), 32'(v[i].rtag));
      if (v[i].wr) begin
        chk($sformatf("v%0d_wr_tag", i), 32'(wr_tag), 32'(v[i].wtag));
        chk($sformatf("v%0d_wr_data", i), wr_data, v[i].wdata);
      end
      if (!v[i].rd && !v[i].wr) chk($sformatf("v%0d_no_bus", i), 32'(bus_seen), 32'h0);
    end

    // reset during the AMO write phase, then a clean LR
    bus_mem[32'h400] = 32'h7;
    lat = 3;
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = OP_ADD; req_addr_i = 32'h400; req_data_i = 32'h1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n = 0;
    while (!(stb_o && we_o) && n < 50) begin @(posedge clk_i); #1; n++; end
    chk("rst_wr_reached", 32'(stb_o && we_o), 32'h1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'({cyc_o, stb_o, we_o, done_o, busy_o}), 32'h0);
    chk("rst_mid_tag", 32'(addr_tag_o), 32'h0);
    resv_v = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    lat = 1;
    run(OP_LR, 32'h400, 32'h0, res, e, n);
    chk("post_rst_lr", res, 32'h7);
    chk("post_rst_cycles", n, 3);
    chk("post_rst_tag", 32'(rd_tag), 32'({MODE_LRSC, LOCK}));

    // randomized ops against the reference model
    resv_v = 1'b0; ref_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      bus_mem[32'h300 + 4 * k] = ra;
      ref_mem[32'h300 + 4 * k] = ra;
    end
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 12);
      ra = 32'h300 + 4 * $urandom_range(0, 3) + (($urandom_range(0, 9) == 0) ? 2 : 0);
      lat = $urandom_range(1, 4);
      req_data_i = $urandom;
      if ($urandom_range(0, 3) == 0) req_data_i = 32'h8000_0000;
      ref_txn(op, ra, req_data_i, eres, ee, en, lat);
      run(op[3:0], ra, req_data_i, res, e, n);
      chk($sformatf("rnd%0d_op%0d_result", k, op), res, eres);
      chk($sformatf("rnd%0d_err", k), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_cycles", k), n, en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
